ucsbece154a_mc_controller: RTL
==============================

# ucsbece154a_mc_controller

Second-generation multicycle RISC-V control unit. It sits beside the multicycle datapath and drives all datapath enables and mux selects from a registered-output FSM. It extends the base instruction set with bne, jalr and the full RV32I register/immediate ALU operation set, using a parametrised-width ALU control bus. It also adds an illegal-opcode fault state and an optional memory-ready wait handshake.

## Interface
- ALUCTRL_W, 4, width of ALUControl_o; must be ≥4
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- op_i  in  7  instruction opcode from IR
- funct3_i  in  3  IR[14:12]
- funct7_i  in  1  IR[30]
- zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  memory access complete (used only with wait feature)
- PCWrite_o  out  1  PC load enable
- MemWrite_o, IRWrite_o, RegWrite_o, AdrSrc_o  out  1 each  datapath enables/selects
- ALUSrcA_o, ALUSrcB_o, ResultSrc_o  out  2 each  mux selects
- ALUControl_o  out  ALUCTRL_W  ALU operation
- ImmSrc_o  out  3  immediate format
- fault_o  out  1  illegal opcode trapped; sticky until reset

## Operation
- ImmSrc (combinational on op_i):
  - lw, ItypeALU, jalr → 000
  - sw → 001
  - beq/bne → 010
  - jal → 011
  - lui → 100
  - other → 000
- ALUOp codes: mem=00 → add; branch=01 → sub; other=10 → decoded from funct3:
  - 000: sub if R-type & funct7, else add
  - 001: sll
  - 010: slt
  - 011: sltu
  - 100: xor
  - 101: sra if funct7, else srl (R and I forms)
  - 110: or
  - 111: and
- ALU control codes, zero-extended to ALUCTRL_W: add 0, sub 1, and 2, or 3, xor 4, slt 5, sll 6, srl 7, sra 8, sltu 9.
- PCWrite_o = Branch_q & (zero_i ^ funct3_i[0]) | PCUpdate_q. beq is taken on zero; bne is taken on !zero.
- State encodings: Fetch 0, Decode 1, MemAdr 2, MemRead 3, MemWB 4, MemWrite 5, ExecuteR 6, ALUWB 7, ExecuteI 8, JAL 9, BR 10, LUI 11, JALRAdr 12, JALR 13, Fault 15.
- State transitions:
  - Fetch → Decode
  - Decode → by opcode: lw/sw → MemAdr; R → ExecuteR; I → ExecuteI; branch → BR; jal → JAL; jalr → JALRAdr; lui → LUI; unknown → Fault
  - MemAdr → MemRead (lw) or MemWrite (sw)
  - MemRead → MemWB
  - ExecuteR, ExecuteI, JAL, JALR → ALUWB
  - JALRAdr → JALR
  - MemWB, MemWrite, ALUWB, BR, LUI → Fetch
  - Fault → Fault
- Control bits per state (PCUpd, Br, MemW, IRW, RegW, SrcA, SrcB, Adr, Res, ALUOp); unlisted fields are don't-care:
  - Fetch: 1,0,0,1,0, 00,10, 0, 10, 00
  - Decode: SrcA 01, SrcB 01, ALUOp 00
  - MemAdr: SrcA 10, SrcB 01, ALUOp 00
  - MemRead: Adr 1
  - MemWB: RegW 1, Res 01
  - MemWrite: MemW 1, Adr 1
  - ExecuteR: SrcA 10, SrcB 00, ALUOp 10
  - ExecuteI: SrcA 10, SrcB 01, ALUOp 10
  - ALUWB: RegW 1, Res 00
  - JAL: PCUpd 1, SrcA 01, SrcB 10, Res 00, ALUOp 00
  - BR: Br 1, SrcA 10, SrcB 00, Res 00, ALUOp 01
  - LUI: RegW 1, Res 11
  - JALRAdr: SrcA 10, SrcB 01, ALUOp 00 (ALUOut ← rs1+imm)
  - JALR: PCUpd 1, SrcA 01, SrcB 10, Res 00, ALUOp 00 (PC ← rs1+imm; ALUOut ← oldPC+4)
  - Fault: all enables 0; fault_o 1

## Timing
- All control outputs except ImmSrc_o, ALUControl_o and PCWrite_o are registered. They are decoded from state_next, so each output is valid in the same cycle as the corresponding state.
- Reset: state_next is forced to Fetch. After any reset edge, state = Fetch, the outputs carry Fetch values (PCWrite_o=1, IRWrite_o=1, ResultSrc_o=10, ALUSrcB_o=10), and fault_o=0.
- Reset asserted mid-instruction abandons the instruction; no further RegWrite_o or MemWrite_o is issued after the reset edge.
- CPI:
  - lw = 5
  - sw, R, I, jal = 4
  - jalr = 5
  - branch, lui = 3
- Branch resolution is combinational on zero_i during the BR cycle.

## Configuration
- UCSBECE154A_MEM_WAIT_EN defined:
  - Fetch, MemRead and MemWrite hold while mem_ready_i=0.
  - IRWrite_o and the PCUpdate term of PCWrite_o are ANDed with mem_ready_i in Fetch.
  - MemWrite_o stays high until the cycle with mem_ready_i=1.
- Undefined: mem_ready_i is ignored, behaviour is fixed-latency, and CPI is as listed above.

## Structure
- Package ucsbece154a_ctrl_pkg holds opcodes, funct3 codes, state encodings, ALUOp codes, ALU control codes and ResultSrc codes.
- Sub-module ucsbece154a_alu_decoder is the combinational ALUOp/funct3/funct7/op[5] → ALUControl map.

## Test plan
- Reset then add (op 0110011, f3 000, f7 0) → states 0,1,6,7,0; ALUControl 0 in ExecuteR; RegWrite_o=1 only in ALUWB.
- sub, then srai (op 0010011, f3 101, f7 1) → ALUControl 1 and 8 respectively.
- bne (f3 001) with zero_i=0 → PCWrite_o=1 in BR; repeat with zero_i=1 → PCWrite_o=0.
- jalr (op 1100111) → states 0,1,12,13,7,0; PCWrite_o=1 only in Fetch and JALR.
- Opcode 0000000 → Fault after Decode, fault_o=1, all enables 0 for 10 cycles; reset → Fetch with fault_o=0.
- With UCSBECE154A_MEM_WAIT_EN, lw with mem_ready_i low for 3 cycles in MemRead → state held 3 extra cycles; MemWB follows the ready cycle.

Source files
------------

// File: rtl/ucsbece154a_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V controller: opcodes, funct3 codes,
// FSM states, ALUOp/ALU control codes, mux-select codes and per-state control decode.
package ucsbece154a_ctrl_pkg;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_SLTU   = 3'b011;
    localparam logic [2:0] F3_XOR    = 3'b100;
    localparam logic [2:0] F3_SR     = 3'b101;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BR       = 4'd10,
        S_LUI      = 4'd11,
        S_JALRADR  = 4'd12,
        S_JALR     = 4'd13,
        S_FAULT    = 4'd15
    } state_t;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMMEXT    = 2'b11;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_op;
        logic       fault;
    } ctrl_t;

    // Don't-care fields are driven to zero so every state has a single clean decode.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.pc_update  = 1'b1;
                c.ir_write   = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
                c.alu_op     = ALUOP_MEM;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_MEM;
            end
            S_MEMADR, S_JALRADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_MEM;
            end
            S_MEMREAD: c.adr_src = 1'b1;
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.result_src = RES_DATA;
            end
            S_MEMWRITE: begin
                c.mem_write = 1'b1;
                c.adr_src   = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.reg_write  = 1'b1;
                c.result_src = RES_ALUOUT;
            end
            S_JAL, S_JALR: begin
                c.pc_update  = 1'b1;
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALUOUT;
                c.alu_op     = ALUOP_MEM;
            end
            S_BR: begin
                c.branch     = 1'b1;
                c.alu_src_a  = SRCA_RS1;
                c.alu_src_b  = SRCB_RS2;
                c.result_src = RES_ALUOUT;
                c.alu_op     = ALUOP_BRANCH;
            end
            S_LUI: begin
                c.reg_write  = 1'b1;
                c.result_src = RES_IMMEXT;
            end
            S_FAULT: c.fault = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] imm_src(input logic [6:0] op);
        logic [2:0] r;
        case (op)
            OP_SW:     r = IMM_S;
            OP_BRANCH: r = IMM_B;
            OP_JAL:    r = IMM_J;
            OP_LUI:    r = IMM_U;
            default:   r = IMM_I;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ucsbece154a_alu_decoder.sv
// Combinational map from ALUOp/funct3/funct7/op[5] to the ALU operation code,
// zero-extended to the configured control-bus width.
module ucsbece154a_alu_decoder
    import ucsbece154a_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 4
) (
    input  logic [1:0]           alu_op_i,
    input  logic [2:0]           funct3_i,
    input  logic                 funct7_i,
    input  logic                 op5_i,
    output logic [ALUCTRL_W-1:0] alu_control_o
);

    logic [3:0] code;

    always_comb begin
        code = ALU_ADD;
        case (alu_op_i)
            ALUOP_MEM:    code = ALU_ADD;
            ALUOP_BRANCH: code = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // Only the register form uses IR[30] to pick sub; addi with a
                    // negative immediate also has IR[30] set.
                    F3_ADDSUB: code = (op5_i && funct7_i) ? ALU_SUB : ALU_ADD;
                    F3_SLL:    code = ALU_SLL;
                    F3_SLT:    code = ALU_SLT;
                    F3_SLTU:   code = ALU_SLTU;
                    F3_XOR:    code = ALU_XOR;
                    F3_SR:     code = funct7_i ? ALU_SRA : ALU_SRL;
                    F3_OR:     code = ALU_OR;
                    F3_AND:    code = ALU_AND;
                    default:   code = ALU_ADD;
                endcase
            end
            default: code = ALU_ADD;
        endcase
    end

    assign alu_control_o = ALUCTRL_W'(code);

endmodule

// File: rtl/ucsbece154a_mc_controller.sv
// Multicycle RISC-V control FSM with registered outputs decoded from the next state.
// Optional memory-ready wait handshake is enabled by defining UCSBECE154A_MEM_WAIT_EN.
module ucsbece154a_mc_controller
    import ucsbece154a_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op_i,
    input  logic [2:0]           funct3_i,
    input  logic                 funct7_i,
    input  logic                 zero_i,
    input  logic                 mem_ready_i,
    output logic                 PCWrite_o,
    output logic                 MemWrite_o,
    output logic                 IRWrite_o,
    output logic                 RegWrite_o,
    output logic                 AdrSrc_o,
    output logic [1:0]           ALUSrcA_o,
    output logic [1:0]           ALUSrcB_o,
    output logic [1:0]           ResultSrc_o,
    output logic [ALUCTRL_W-1:0] ALUControl_o,
    output logic [2:0]           ImmSrc_o,
    output logic                 fault_o
);

    state_t state_q, state_d;
    ctrl_t  ctrl_q;
    logic   fetch_go;

`ifdef UCSBECE154A_MEM_WAIT_EN
    assign fetch_go = (state_q != S_FETCH) || mem_ready_i;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready_i;
    assign fetch_go         = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        if (reset) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    state_d = S_DECODE;
`ifdef UCSBECE154A_MEM_WAIT_EN
                    if (!mem_ready_i) state_d = S_FETCH;
`endif
                end
                S_DECODE: begin
                    case (op_i)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_EXECUTER;
                        OP_ITYPE:     state_d = S_EXECUTEI;
                        OP_BRANCH:    state_d = S_BR;
                        OP_JAL:       state_d = S_JAL;
                        OP_JALR:      state_d = S_JALRADR;
                        OP_LUI:       state_d = S_LUI;
                        default:      state_d = S_FAULT;
                    endcase
                end
                S_MEMADR: state_d = (op_i == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD: begin
                    state_d = S_MEMWB;
`ifdef UCSBECE154A_MEM_WAIT_EN
                    if (!mem_ready_i) state_d = S_MEMREAD;
`endif
                end
                S_MEMWRITE: begin
                    state_d = S_FETCH;
`ifdef UCSBECE154A_MEM_WAIT_EN
                    if (!mem_ready_i) state_d = S_MEMWRITE;
`endif
                end
                S_EXECUTER, S_EXECUTEI, S_JAL, S_JALR: state_d = S_ALUWB;
                S_JALRADR:                             state_d = S_JALR;
                S_MEMWB, S_ALUWB, S_BR, S_LUI:         state_d = S_FETCH;
                S_FAULT:                               state_d = S_FAULT;
                default:                               state_d = S_FETCH;
            endcase
        end
    end

    // Outputs are decoded from state_d so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        state_q <= state_d;
        ctrl_q  <= state_ctrl(state_d);
    end

    assign MemWrite_o  = ctrl_q.mem_write;
    assign IRWrite_o   = ctrl_q.ir_write & fetch_go;
    assign RegWrite_o  = ctrl_q.reg_write;
    assign AdrSrc_o    = ctrl_q.adr_src;
    assign ALUSrcA_o   = ctrl_q.alu_src_a;
    assign ALUSrcB_o   = ctrl_q.alu_src_b;
    assign ResultSrc_o = ctrl_q.result_src;
    assign fault_o     = ctrl_q.fault;
    assign ImmSrc_o    = imm_src(op_i);

    // funct3[0] distinguishes bne from beq, inverting the sense of the zero flag.
    assign PCWrite_o = (ctrl_q.branch & (zero_i ^ funct3_i[0]))
                     | (ctrl_q.pc_update & fetch_go);

    ucsbece154a_alu_decoder #(
        .ALUCTRL_W(ALUCTRL_W)
    ) u_alu_decoder (
        .alu_op_i     (ctrl_q.alu_op),
        .funct3_i     (funct3_i),
        .funct7_i     (funct7_i),
        .op5_i        (op_i[5]),
        .alu_control_o(ALUControl_o)
    );

endmodule
